// File: rtl/idex_pipe_reg.sv
// rtl/idex_pipe_reg.sv - ID->EX pipeline register with skid buffer, flush, bubble and stall counter
module idex_pipe_reg #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ALUOP_W  = 8,
   parameter int ALUSEL_W = 3,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                id_valid,
   output logic                id_ready,
   input  logic [ALUOP_W-1:0]  id_aluop,
   input  logic [ALUSEL_W-1:0] id_alusel,
   input  logic [DATA_W-1:0]   id_reg1,
   input  logic [DATA_W-1:0]   id_reg2,
   input  logic [ADDR_W-1:0]   id_wreg_addr,
   input  logic                id_wreg_enable,
   input  logic [DATA_W-1:0]   id_link_address,
   input  logic                id_is_in_delayslot,
   input  logic                next_inst_in_delayslot_i,
   output logic                ex_valid,
   input  logic                ex_ready,
   output logic [ALUOP_W-1:0]  ex_aluop,
   output logic [ALUSEL_W-1:0] ex_alusel,
   output logic [DATA_W-1:0]   ex_reg1,
   output logic [DATA_W-1:0]   ex_reg2,
   output logic [ADDR_W-1:0]   ex_wreg_addr,
   output logic                ex_wreg_enable,
   output logic [DATA_W-1:0]   ex_link_address,
   output logic                ex_is_in_delayslot,
   output logic                is_in_delayslot_o,
   output logic [CNT_W-1:0]    stall_cnt
);

   localparam int PAY_W = ALUOP_W + ALUSEL_W + 3*DATA_W + ADDR_W + 2;

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   state_t             state, state_nx;
   logic [PAY_W-1:0]   main_q, main_nx, skid_q, id_pay;
   logic               skid_load;
   logic               accept, retire;

   assign id_pay = {id_aluop, id_alusel, id_reg1, id_reg2, id_wreg_addr,
                    id_wreg_enable, id_link_address, id_is_in_delayslot};

   // An all-zero payload is the NOP bubble.
   assign {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wreg_addr,
           ex_wreg_enable, ex_link_address, ex_is_in_delayslot} = main_q;

   assign accept = id_valid & id_ready;
   assign retire = ex_valid & ex_ready;

   always_comb begin
      state_nx  = state;
      main_nx   = main_q;
      skid_load = 1'b0;
      case (state)
         EMPTY: begin
            if (accept) begin
               state_nx = ONE;
               main_nx  = id_pay;
            end
         end
         ONE: begin
            if (accept && retire) begin
               main_nx = id_pay;
            end else if (accept) begin
               state_nx  = TWO;
               skid_load = 1'b1;
            end else if (retire) begin
               state_nx = EMPTY;
               main_nx  = '0;
            end
         end
         TWO: begin
            if (retire) begin
               state_nx = ONE;
               main_nx  = skid_q;
            end
         end
         default: begin
            state_nx = EMPTY;
            main_nx  = '0;
         end
      endcase
   end

   // id_ready and ex_valid are flops loaded from the next state, so ex_ready never reaches id_ready combinationally.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state             <= EMPTY;
         main_q            <= '0;
         skid_q            <= '0;
         id_ready          <= 1'b1;
         ex_valid          <= 1'b0;
         is_in_delayslot_o <= 1'b0;
      end else begin
         state    <= state_nx;
         main_q   <= main_nx;
         id_ready <= (state_nx != TWO);
         ex_valid <= (state_nx != EMPTY);
         if (skid_load)
            skid_q <= id_pay;
         if (accept)
            is_in_delayslot_o <= next_inst_in_delayslot_i;
      end
   end

   // Flush leaves the counter alone; it is a performance statistic.
   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= '0;
      else if (ex_valid && !ex_ready && (stall_cnt != {CNT_W{1'b1}}))
         stall_cnt <= stall_cnt + 1'b1;
   end

endmodule

// File: tb/tb_idex_pipe_reg.sv
// tb/tb_idex_pipe_reg.sv - randomized queue-model bench for idex_pipe_reg
module tb_idex_pipe_reg;

   localparam int DW = 32, AW = 5, OW = 8, SW = 3, CW = 4;
   localparam int PW = OW + SW + 3*DW + AW + 2;
   localparam int CNT_MAX = 15;

   logic clk = 1'b0;
   logic rst, flush, id_valid, ex_ready, ns;
   logic [PW-1:0] id_pay;
   logic id_ready, ex_valid, dsl;
   logic [CW-1:0] stall_cnt;
   logic [OW-1:0] id_aluop, ex_aluop;
   logic [SW-1:0] id_alusel, ex_alusel;
   logic [DW-1:0] id_reg1, id_reg2, id_link, ex_reg1, ex_reg2, ex_link;
   logic [AW-1:0] id_waddr, ex_waddr;
   logic id_wen, id_ds, ex_wen, ex_ds;
   logic [PW-1:0] ex_pay;

   assign {id_aluop, id_alusel, id_reg1, id_reg2, id_waddr, id_wen, id_link, id_ds} = id_pay;
   assign ex_pay = {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_waddr, ex_wen, ex_link, ex_ds};

   idex_pipe_reg #(.DATA_W(DW), .ADDR_W(AW), .ALUOP_W(OW), .ALUSEL_W(SW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_aluop(id_aluop), .id_alusel(id_alusel), .id_reg1(id_reg1), .id_reg2(id_reg2),
      .id_wreg_addr(id_waddr), .id_wreg_enable(id_wen), .id_link_address(id_link),
      .id_is_in_delayslot(id_ds), .next_inst_in_delayslot_i(ns),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_aluop(ex_aluop), .ex_alusel(ex_alusel), .ex_reg1(ex_reg1), .ex_reg2(ex_reg2),
      .ex_wreg_addr(ex_waddr), .ex_wreg_enable(ex_wen), .ex_link_address(ex_link),
      .ex_is_in_delayslot(ex_ds), .is_in_delayslot_o(dsl), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference: a FIFO of at most two in-flight instructions.
   logic [PW-1:0] q[$];
   logic          m_dsl;
   int            m_cnt;

   function automatic logic m_valid();
      return q.size() != 0;
   endfunction

   function automatic logic m_ready();
      return q.size() < 2;
   endfunction

   function automatic logic [PW-1:0] m_pay();
      return (q.size() != 0) ? q[0] : '0;
   endfunction

   function automatic logic [PW-1:0] rand_pay(input logic [DW-1:0] r1);
      logic [127:0] r;
      logic [PW-1:0] p;
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      p = r[PW-1:0];
      p[71 +: DW] = r1;
      return p;
   endfunction

   task automatic model_step();
      logic acc, ret;
      if (rst) begin
         q.delete();
         m_dsl = 1'b0;
         m_cnt = 0;
      end else begin
         if (m_valid() && !ex_ready && m_cnt < CNT_MAX)
            m_cnt++;
         if (flush) begin
            q.delete();
            m_dsl = 1'b0;
         end else begin
            acc = id_valid && m_ready();
            ret = m_valid() && ex_ready;
            if (ret) void'(q.pop_front());
            if (acc) begin
               q.push_back(id_pay);
               m_dsl = ns;
            end
         end
      end
   endtask

   task automatic cycle(input logic v, input logic [PW-1:0] p, input logic er,
                        input logic fl, input logic n);
      id_valid = v; id_pay = p; ex_ready = er; flush = fl; ns = n;
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (ex_valid !== 1'b0 || id_ready !== 1'b1 || ex_pay !== '0 || dsl !== 1'b0 || stall_cnt !== '0) begin
         errors++;
         $display("FAIL reset: valid=%b ready=%b pay=%h dsl=%b cnt=%0d, required 0 1 0 0 0",
                  ex_valid, id_ready, ex_pay, dsl, stall_cnt);
      end
   endtask

   task automatic test_stream();
      logic [DW-1:0] vals [3] = '{32'h11, 32'h22, 32'h33};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, rand_pay(vals[i]), 1'b1, 1'b0, 1'b0);
         checks++;
         if (ex_valid !== 1'b1 || ex_reg1 !== vals[i] || ex_pay !== m_pay() || stall_cnt !== '0) begin
            errors++;
            $display("FAIL stream[%0d]: valid=%b reg1=%h cnt=%0d, required 1 %h 0", i, ex_valid, ex_reg1, stall_cnt, vals[i]);
         end
      end
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (ex_valid !== 1'b0 || ex_pay !== '0) begin
         errors++;
         $display("FAIL stream_drain: valid=%b pay=%h, required 0 0", ex_valid, ex_pay);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      cycle(1'b1, rand_pay(32'hA0), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, rand_pay(32'hB0), 1'b0, 1'b0, 1'b0);
      checks++;
      if (id_ready !== 1'b0 || ex_reg1 !== 32'hA0) begin
         errors++;
         $display("FAIL bp_two: id_ready=%b reg1=%h, required 0 a0", id_ready, ex_reg1);
      end
      cycle(1'b1, rand_pay(32'hC0), 1'b0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (ex_reg1 !== 32'hA0 || stall_cnt !== 4'd3 || ex_pay !== m_pay()) begin
         errors++;
         $display("FAIL bp_hold: reg1=%h cnt=%0d, required a0 3", ex_reg1, stall_cnt);
      end
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (ex_valid !== 1'b1 || ex_reg1 !== 32'hB0 || id_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: valid=%b reg1=%h ready=%b, required 1 b0 1", ex_valid, ex_reg1, id_ready);
      end
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (ex_valid !== 1'b0 || ex_pay !== '0) begin
         errors++;
         $display("FAIL bp_drain: valid=%b pay=%h, required 0 0", ex_valid, ex_pay);
      end
   endtask

   task automatic test_flush();
      do_reset();
      cycle(1'b1, rand_pay(32'h1), 1'b0, 1'b0, 1'b1);
      cycle(1'b1, rand_pay(32'h2), 1'b0, 1'b0, 1'b1);
      cycle(1'b1, rand_pay(32'hDEAD), 1'b0, 1'b1, 1'b1);
      checks++;
      if (ex_valid !== 1'b0 || ex_wen !== 1'b0 || id_ready !== 1'b1 || dsl !== 1'b0) begin
         errors++;
         $display("FAIL flush: valid=%b wen=%b ready=%b dsl=%b, required 0 0 1 0", ex_valid, ex_wen, id_ready, dsl);
      end
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
         checks++;
         if (ex_valid !== 1'b0 || ex_reg1 === 32'hDEAD) begin
            errors++;
            $display("FAIL flush_drop[%0d]: valid=%b reg1=%h, required 0", i, ex_valid, ex_reg1);
         end
      end
   endtask

   task automatic test_delayslot();
      do_reset();
      cycle(1'b1, rand_pay(32'h5), 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, '0, 1'b1, 1'b0, logic'(i[0]));
         checks++;
         if (dsl !== 1'b1) begin
            errors++;
            $display("FAIL delayslot_hold[%0d]: dsl=%b, required 1", i, dsl);
         end
      end
      cycle(1'b1, rand_pay(32'h6), 1'b1, 1'b0, 1'b0);
      checks++;
      if (dsl !== 1'b0) begin
         errors++;
         $display("FAIL delayslot_clear: dsl=%b, required 0", dsl);
      end
   endtask

   task automatic test_saturate_reset();
      do_reset();
      cycle(1'b1, rand_pay(32'h7), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++)
         cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (stall_cnt !== 4'd15 || ex_reg1 !== 32'h7) begin
         errors++;
         $display("FAIL saturate: cnt=%0d reg1=%h, required 15 7", stall_cnt, ex_reg1);
      end
      cycle(1'b1, rand_pay(32'h8), 1'b0, 1'b0, 1'b1);
      rst = 1'b1;
      cycle(1'b1, rand_pay(32'h9), 1'b0, 1'b0, 1'b1);
      rst = 1'b0;
      checks++;
      if (ex_valid !== 1'b0 || id_ready !== 1'b1 || ex_pay !== '0 || dsl !== 1'b0 || stall_cnt !== '0) begin
         errors++;
         $display("FAIL mid_reset: valid=%b ready=%b pay=%h dsl=%b cnt=%0d, required 0 1 0 0 0",
                  ex_valid, id_ready, ex_pay, dsl, stall_cnt);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         cycle($urandom_range(0, 9) < 7, rand_pay($urandom()), $urandom_range(0, 9) < 5,
               $urandom_range(0, 29) == 0, logic'($urandom_range(0, 1)));
         rst = 1'b0;
         checks++;
         if (ex_valid !== m_valid() || id_ready !== m_ready() || ex_pay !== m_pay() ||
             dsl !== m_dsl || stall_cnt !== CW'(m_cnt)) begin
            errors++;
            $display("FAIL random[%0d]: valid=%b ready=%b dsl=%b cnt=%0d pay=%h, required %b %b %b %0d %h",
                     i, ex_valid, id_ready, dsl, stall_cnt, ex_pay, m_valid(), m_ready(), m_dsl, m_cnt, m_pay());
         end
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b0; ns = 1'b0; id_pay = '0;
      m_dsl = 1'b0; m_cnt = 0;
      @(negedge clk);
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_delayslot();
      test_random();
      test_saturate_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
